// File: rtl/ac_resonance_detector.sv
// Captures one magnitude sample per sweep point, then locates the resonance peak and the
// half-power band around it by walking outward from the peak while mag >= 0.707 * peak.
module ac_resonance_detector #(
  parameter int unsigned W    = 16,
  parameter int unsigned IDXW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sample_valid,
  input  logic [W-1:0]    sample_mag,
  output logic            sample_ready,
  output logic            busy,
  output logic            done,
  output logic [IDXW-1:0] peak_idx,
  output logic [W-1:0]    peak_mag,
  output logic [IDXW-1:0] lo_idx,
  output logic [IDXW-1:0] hi_idx,
  output logic            lo_open,
  output logic            hi_open
);

  localparam int unsigned N = 2 ** IDXW;
  localparam logic [IDXW-1:0] LastIdx = {IDXW{1'b1}};

  typedef enum logic [2:0] {
    StIdle, StCapture, StThresh, StScanLo, StScanHi, StDone
  } state_e;

  state_e          state_q;
  logic [W-1:0]    mem_q [N];
  logic [IDXW-1:0] wcnt_q;
  logic [IDXW-1:0] ptr_q;
  logic [W-1:0]    thr_q;

  logic            xfer;
  logic [W+7:0]    thr_prod;
  logic [IDXW-1:0] ptr_dn;
  logic [IDXW-1:0] ptr_up;
  logic [W-1:0]    mag_dn;
  logic [W-1:0]    mag_up;

  assign sample_ready = (state_q == StCapture);
  assign busy         = (state_q == StCapture) || (state_q == StThresh) ||
                        (state_q == StScanLo)  || (state_q == StScanHi);
  assign done         = (state_q == StDone);
  assign xfer         = sample_valid && sample_ready;

  // 181/256 approximates 1/sqrt(2), the half-power ratio on a magnitude scale.
  assign thr_prod = {8'd0, peak_mag} * (W + 8)'(181);

  assign ptr_dn = ptr_q - 1'b1;
  assign ptr_up = ptr_q + 1'b1;
  assign mag_dn = mem_q[ptr_dn];
  assign mag_up = mem_q[ptr_up];

  always_ff @(posedge clk) begin
    if (xfer) begin
      mem_q[wcnt_q] <= sample_mag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      wcnt_q   <= '0;
      ptr_q    <= '0;
      thr_q    <= '0;
      peak_idx <= '0;
      peak_mag <= '0;
      lo_idx   <= '0;
      hi_idx   <= '0;
      lo_open  <= 1'b0;
      hi_open  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            wcnt_q   <= '0;
            peak_idx <= '0;
            peak_mag <= '0;
            lo_open  <= 1'b0;
            hi_open  <= 1'b0;
            state_q  <= StCapture;
          end
        end
        StCapture: begin
          if (xfer) begin
            // Strict compare keeps the lowest index on ties.
            if (sample_mag > peak_mag) begin
              peak_mag <= sample_mag;
              peak_idx <= wcnt_q;
            end
            wcnt_q <= wcnt_q + 1'b1;
            if (wcnt_q == LastIdx) begin
              state_q <= StThresh;
            end
          end
        end
        StThresh: begin
          thr_q   <= thr_prod[W+7:8];
          ptr_q   <= peak_idx;
          state_q <= StScanLo;
        end
        StScanLo: begin
          if (ptr_q == '0) begin
            lo_idx  <= '0;
            lo_open <= 1'b1;
            ptr_q   <= peak_idx;
            state_q <= StScanHi;
          end else if (mag_dn >= thr_q) begin
            ptr_q <= ptr_dn;
          end else begin
            lo_idx  <= ptr_q;
            ptr_q   <= peak_idx;
            state_q <= StScanHi;
          end
        end
        StScanHi: begin
          if (ptr_q == LastIdx) begin
            hi_idx  <= LastIdx;
            hi_open <= 1'b1;
            state_q <= StDone;
          end else if (mag_up >= thr_q) begin
            ptr_q <= ptr_up;
          end else begin
            hi_idx  <= ptr_q;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
